// File: rtl/comparison_display_pkg.sv
// ---------------------------------------------------------------------------
// comparison_display_pkg
// Shared definitions for the comparison result display:
//   scan_state_t : which of the four digit slots is currently being driven
//   SEG_OFF      : segment word that turns every segment off (active-low)
//   AN_OFF       : anode word that disables every digit (active-low)
//   HEX_SEG      : 16-entry hex-to-segment table, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package comparison_display_pkg;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Active-low segment patterns, listed from F down to 0 so that
   // HEX_SEG[n] is the pattern for hex digit n. b and d are lowercase
   // so they cannot be confused with 8 and 0.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0001110,
      7'b0000110,
      7'b0100001,
      7'b1000110,
      7'b0000011,
      7'b0001000,
      7'b0010000,
      7'b0000000,
      7'b1111000,
      7'b0000010,
      7'b0010010,
      7'b0011001,
      7'b0110000,
      7'b0100100,
      7'b1111001,
      7'b1000000
   };

endpackage

// File: rtl/comparison_display_if.sv
// ---------------------------------------------------------------------------
// comparison_display_if
// Bundles the capture inputs and the display outputs of comparison_display.
//   load   : single-cycle strobe, capture value/select on this edge
//   value  : 8-bit comparison result word
//   select : comparator mode that produced value (0 EQ, 1 GT, 2 LT, 3 MAX)
//   blank  : level, forces the display dark while high
//   seg    : segments {g,f,e,d,c,b,a}, active-low
//   anode  : digit enables, active-low, bit n drives digit n
// The master side drives the capture inputs; the slave is the display.
// ---------------------------------------------------------------------------
interface comparison_display_if;

   logic       load;
   logic [7:0] value;
   logic [1:0] select;
   logic       blank;
   logic [6:0] seg;
   logic [3:0] anode;

   modport master (
      output load,
      output value,
      output select,
      output blank,
      input  seg,
      input  anode
   );

   modport slave (
      input  load,
      input  value,
      input  select,
      input  blank,
      output seg,
      output anode
   );

endinterface

// File: rtl/comparison_display_hex_to_seg.sv
// ---------------------------------------------------------------------------
// hex_to_seg
// Purely combinational hex digit decoder.
//   digit : 4-bit hex digit
//   seg   : active-low segment pattern {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seg
   import comparison_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // The decode is a straight table lookup so the patterns live in one place.
   assign seg = HEX_SEG[digit];

endmodule

// File: rtl/comparison_display.sv
// ---------------------------------------------------------------------------
// comparison_display
// Time-multiplexed four-digit driver for a comparator result.
//   clk : sole clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : comparison_display_if.slave (load/value/select/blank in,
//         seg/anode out, both outputs registered)
// Digit 0 shows value[3:0], digit 1 shows value[7:4] with leading-zero
// suppression, digit 2 is always dark and digit 3 shows the select code.
// Parameter REFRESH_COUNT is the number of clocks each digit stays lit
// and must be at least 2.
// ---------------------------------------------------------------------------
module comparison_display
   import comparison_display_pkg::*;
#(
   parameter int REFRESH_COUNT = 50000
)
(
   input  logic                 clk,
   input  logic                 rst,
   comparison_display_if.slave  bus
);

   localparam int            CW       = $clog2(REFRESH_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_COUNT - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   scan_state_t   state_q, state_d;
   logic [7:0]    hold_q, hold_d;
   logic [1:0]    hold_sel_q, hold_sel_d;
   logic [7:0]    shadow_q, shadow_d;
   logic [1:0]    shadow_sel_q, shadow_sel_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    anode_q, anode_d;
   logic          boundary;
   logic [3:0]    hex_digit;
   logic [6:0]    hex_seg;

   assign boundary = (cnt_q == CNT_LAST);

   // Next-state logic for the refresh counter, scan FSM and the two
   // capture stages. The hold register takes every load so the last one
   // in a digit period wins; the shadow only moves on a boundary so a
   // digit never changes while lit. A load that lands exactly on a
   // boundary bypasses the hold register so the new word is not delayed
   // by a whole digit period.
   always_comb begin
      cnt_d        = boundary ? '0 : cnt_q + CW'(1);
      state_d      = state_q;
      hold_d       = hold_q;
      hold_sel_d   = hold_sel_q;
      shadow_d     = shadow_q;
      shadow_sel_d = shadow_sel_q;

      if (bus.load) begin
         hold_d     = bus.value;
         hold_sel_d = bus.select;
      end

      if (boundary) begin
         shadow_d     = bus.load ? bus.value  : hold_q;
         shadow_sel_d = bus.load ? bus.select : hold_sel_q;
         case (state_q)
            DIG0:    state_d = DIG1;
            DIG1:    state_d = DIG2;
            DIG2:    state_d = DIG3;
            default: state_d = DIG0;
         endcase
      end
   end

   // Pick the nibble for the slot being scanned so that a single decoder
   // serves all digits. Digit 2 is never lit, so its nibble is a don't-care.
   always_comb begin
      case (state_q)
         DIG0:    hex_digit = shadow_q[3:0];
         DIG1:    hex_digit = shadow_q[7:4];
         DIG3:    hex_digit = {2'b00, shadow_sel_q};
         default: hex_digit = 4'h0;
      endcase
   end

   hex_to_seg u_hex_to_seg (
      .digit (hex_digit),
      .seg   (hex_seg)
   );

   // Output word for the current slot. Everything defaults to dark; only
   // a lit slot with blank low enables its own anode. Blank is a level
   // mask on the outputs only, so the scan keeps running underneath it.
   always_comb begin
      seg_d   = SEG_OFF;
      anode_d = AN_OFF;
      if (!bus.blank) begin
         case (state_q)
            DIG0: begin
               anode_d = 4'b1110;
               seg_d   = hex_seg;
            end
            DIG1: begin
               if (shadow_q[7:4] != 4'h0) begin
                  anode_d = 4'b1101;
                  seg_d   = hex_seg;
               end
            end
            DIG3: begin
               anode_d = 4'b0111;
               seg_d   = hex_seg;
            end
            default: begin
               anode_d = AN_OFF;
               seg_d   = SEG_OFF;
            end
         endcase
      end
   end

   // All state, including the display outputs, is registered here. Reset
   // darkens the display immediately and drops any capture in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         state_q      <= DIG0;
         hold_q       <= 8'h00;
         hold_sel_q   <= 2'd0;
         shadow_q     <= 8'h00;
         shadow_sel_q <= 2'd0;
         seg_q        <= SEG_OFF;
         anode_q      <= AN_OFF;
      end else begin
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         hold_q       <= hold_d;
         hold_sel_q   <= hold_sel_d;
         shadow_q     <= shadow_d;
         shadow_sel_q <= shadow_sel_d;
         seg_q        <= seg_d;
         anode_q      <= anode_d;
      end
   end

   assign bus.seg   = seg_q;
   assign bus.anode = anode_q;

endmodule

// File: doc/comparison_display.md
COMPARISON_DISPLAY -- requirements
Module: comparison_display

Interface
REQ-001 Parameter REFRESH_COUNT, default 50000, clock cycles each digit is displayed (must be >= 2).
REQ-002 Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Load  input  1  single-cycle strobe: capture Value/Select this edge.
REQ-005 Value  input  8  comparison result word from the comparator stage.
REQ-006 Select  input  2  comparator mode that produced Value (0 EQ, 1 GT, 2 LT, 3 MAX).
REQ-007 Blank  input  1  level: force display dark while high.
REQ-008 Seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 Anode  output  4  digit enables, active-low, bit n drives digit n, registered.

Function
REQ-010 Hold register H[7:0]/HS[1:0] SHALL load Value/Select at every edge with Load=1; several Loads in one digit period: last wins.
REQ-011 Refresh counter SHALL count 0..REFRESH_COUNT-1 and wrap to 0; the wrap edge is a "boundary".
REQ-012 Scan FSM states DIG0->DIG1->DIG2->DIG3->DIG0, advancing only on a boundary; no other transitions.
REQ-013 Shadow register D[7:0]/DS[1:0] SHALL copy H/HS only on a boundary, so digit contents never change mid-digit.
REQ-014 Load coincident with a boundary: D/DS SHALL take Value/Select directly (new value, not old H).
REQ-015 DIG0 shows hex D[3:0]; DIG1 shows hex D[7:4]; DIG2 always dark; DIG3 shows DS as digit 0-3.
REQ-016 Leading-zero suppression: in DIG1 with D[7:4]=0, Anode SHALL be 1111 and Seg 1111111.
REQ-017 Dark slot (DIG2, suppressed DIG1, or Blank=1): Anode=1111, Seg=1111111.
REQ-018 Lit slot: exactly one Anode bit low (DIGn -> bit n low), Seg = hex pattern of the digit.
REQ-019 Seg/Anode SHALL be registered from FSM state and shadow: they reflect a state one cycle after it is entered.
REQ-020 Blank SHALL not stop counter, FSM or capture; deasserting resumes at the current scan state.
REQ-021 Hex patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 5=0010010, A=0001000; remaining digits standard 7-seg, B/D lowercase.
REQ-022 Value/Select sampled only on Load; unused otherwise (no combinational input-to-output path).

Reset
REQ-023 Reset SHALL immediately (asynchronously) force Anode=1111, Seg=1111111.
REQ-024 Reset SHALL clear counter to 0, FSM to DIG0, H/HS/D/DS to 0.
REQ-025 Reset asserted mid-digit or mid-Load SHALL discard the pending capture; first boundary after release occurs REFRESH_COUNT cycles later.

Structure
REQ-026 Package comparison_display_pkg SHALL hold the scan-state enum, the 16-entry hex segment table, and SEG_OFF/AN_OFF constants.
REQ-027 Combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out) SHALL be instantiated once, muxed by scan state.

Verification (REFRESH_COUNT=4)
REQ-028 Reset pulse mid-scan -> Anode=1111, Seg=1111111 same cycle; after release FSM DIG0, first advance at cycle 4.
REQ-029 Load Value=0x05, Select=2 -> after next boundary: DIG0 Anode=1110 Seg=0010010; DIG1 dark (suppressed); DIG3 Anode=0111 Seg=0100100.
REQ-030 Load Value=0xA3 -> DIG1 Anode=1101 Seg=0001000; DIG0 Anode=1110 Seg=0110000.
REQ-031 Load 0x01 then 0x03 within one digit period -> only 0x03 displayed; Load exactly on boundary -> new value shown in that slot.
REQ-032 Blank high across two full scans -> Anode=1111 throughout; FSM keeps cycling; drop Blank -> correct digit lit next cycle.
